// File: rtl/sel_mux_fifo.sv
// sel_mux_fifo: one-hot channel mux feeding a first-word-fall-through FIFO
// with valid/ready handshakes on both sides.
// Optional build macro SEL_ONEHOT_CHECK_EN adds select-legality checking
// (per-entry error flag plus a saturating 16-bit error counter).
module sel_mux_fifo #(
    parameter int unsigned NUM_SW_INST = 5,
    parameter int unsigned W_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [W_WIDTH*NUM_SW_INST-1:0] data_in,
    input  logic [NUM_SW_INST-1:0]         sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [W_WIDTH-1:0]             data_out,
    output logic                           err_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [15:0]                    err_cnt
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [W_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [W_WIDTH-1:0] mux_word;
    logic [W_WIDTH-1:0] wr_word;
    logic               push;
    logic               pop;

    assign in_ready  = (count_q != DEPTH_C);
    assign out_valid = (count_q != '0);

    // Pushes/pops presented while reset is asserted are discarded.
    assign push = rst_n && in_valid && in_ready;
    assign pop  = rst_n && out_valid && out_ready;

    assign data_out = out_valid ? mem_q[rd_ptr_q] : '0;

    // AND-OR reduction of the channels selected by sel.
    always_comb begin
        mux_word = '0;
        for (int unsigned k = 0; k < NUM_SW_INST; k++) begin
            if (sel[k]) begin
                mux_word = mux_word | data_in[k*W_WIDTH +: W_WIDTH];
            end
        end
    end

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

`ifdef SEL_ONEHOT_CHECK_EN
    logic        sel_legal;
    logic        err_mem_q [FIFO_DEPTH];
    logic [15:0] err_cnt_q, err_cnt_d;

    assign sel_legal = $onehot(sel);
    assign wr_word   = sel_legal ? mux_word : '0;
    assign err_out   = out_valid ? err_mem_q[rd_ptr_q] : 1'b0;
    assign err_cnt   = err_cnt_q;

    // Saturating count of illegal selects that were accepted.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && !sel_legal && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Per-entry error flags, written alongside the data word.
    always_ff @(posedge clk) begin
        if (push) begin
            err_mem_q[wr_ptr_q] <= !sel_legal;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`else
    assign wr_word = mux_word;
    assign err_out = 1'b0;
    assign err_cnt = '0;
`endif

endmodule
